// File: rtl/dvfs_ldo_ramp.sv
// rtl/dvfs_ldo_ramp.sv - debounced, rate-limited LDO control word ramp with req/ack and settle (option: DVFS_RAMP_DOWN_FAST_EN)
module dvfs_ldo_ramp #(
    parameter int W        = 8,
    parameter int SETTLE_W = 10,
    parameter int STAB_W   = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [W-1:0]        freq_target,
    input  logic [STAB_W-1:0]   stable_cycles,
    input  logic [3:0]          step_size,
    input  logic [SETTLE_W-1:0] settle_cycles,
    input  logic                ldo_ack,
    output logic                ldo_req,
    output logic [W-1:0]        ldo_ctrl,
    output logic                busy,
    output logic                ramp_up
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [W-1:0]        cand;
    logic [STAB_W-1:0]   stab_cnt;
    logic [SETTLE_W-1:0] settle_cnt;

    logic [W-1:0]        ctrl_nxt;
    logic                req_nxt;
    logic                up_nxt;
    logic                busy_nxt;
    logic [SETTLE_W-1:0] settle_nxt;

    logic                committed;
    logic                start_step;
    logic [3:0]          step_eff;
    logic [W:0]          step_ext;
    logic [W:0]          cand_ext;
    logic [W:0]          sum_up;
    logic [W-1:0]        up_word;
    logic [W-1:0]        dn_word;

    // A candidate is trusted once it has been seen unchanged for stable_cycles cycles.
    assign committed  = (stab_cnt >= stable_cycles);
    assign start_step = enable && committed && (cand != ldo_ctrl);

    // Step words are computed one bit wider so the clamp to cand can never wrap.
    assign step_eff = (step_size == 4'd0) ? 4'd1 : step_size;
    assign step_ext = {{(W-3){1'b0}}, step_eff};
    assign cand_ext = {1'b0, cand};
    assign sum_up   = {1'b0, ldo_ctrl} + step_ext;
    assign up_word  = (sum_up > cand_ext) ? cand : sum_up[W-1:0];

`ifdef DVFS_RAMP_DOWN_FAST_EN
    // Lowering the voltage is safe, so downward moves jump straight to the target.
    assign dn_word = cand;
`else
    logic [W:0] diff_dn;
    assign diff_dn = {1'b0, ldo_ctrl} - step_ext;
    assign dn_word = (diff_dn[W] || (diff_dn < cand_ext)) ? cand : diff_dn[W-1:0];
`endif

    // Debounce the incoming target every cycle regardless of ramp state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cand     <= '0;
            stab_cnt <= '0;
        end else if (freq_target != cand) begin
            cand     <= freq_target;
            stab_cnt <= '0;
        end else if (stab_cnt != {STAB_W{1'b1}}) begin
            stab_cnt <= stab_cnt + STAB_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a handshake, once started, always runs to completion.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_step) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ldo_ack) begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and settle counter.
    always_comb begin
        ctrl_nxt   = ldo_ctrl;
        req_nxt    = ldo_req;
        up_nxt     = ramp_up;
        settle_nxt = settle_cnt;
        case (state)
            ST_IDLE: begin
                if (start_step) begin
                    req_nxt = 1'b1;
                    if (cand > ldo_ctrl) begin
                        ctrl_nxt = up_word;
                        up_nxt   = 1'b1;
                    end else begin
                        ctrl_nxt = dn_word;
                        up_nxt   = 1'b0;
                    end
                end
            end
            ST_REQ: begin
                if (ldo_ack) begin
                    req_nxt    = 1'b0;
                    settle_nxt = settle_cycles;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt != '0) begin
                    settle_nxt = settle_cnt - SETTLE_W'(1);
                end
            end
            default: req_nxt = 1'b0;
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

    // Output and settle-counter registers; reset drops ldo_req even mid-handshake.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ldo_ctrl   <= '0;
            ldo_req    <= 1'b0;
            ramp_up    <= 1'b0;
            busy       <= 1'b0;
            settle_cnt <= '0;
        end else begin
            ldo_ctrl   <= ctrl_nxt;
            ldo_req    <= req_nxt;
            ramp_up    <= up_nxt;
            busy       <= busy_nxt;
            settle_cnt <= settle_nxt;
        end
    end

endmodule
